// File: rtl/bcd_excess3_sched_if.sv
// Handshake bundle between two BCD requesters, the shared Excess-3 converter and its consumer.
// The slave modport is the converter's view; master is the requester/consumer side.
interface bcd_excess3_sched_if #(
  parameter int N_DIGITS = 4
);
  logic                    req0_valid;
  logic [4*N_DIGITS-1:0]   req0_data;
  logic                    req0_ready;
  logic                    req1_valid;
  logic [4*N_DIGITS-1:0]   req1_data;
  logic                    req1_ready;
  logic                    out_valid;
  logic [4*N_DIGITS-1:0]   out_data;
  logic                    out_err;
  logic                    out_src;
  logic                    out_ready;
  logic                    busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_err, out_src, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_err, out_src, busy
  );
endinterface

// File: rtl/bcd_excess3_sched.sv
// Two-requester round-robin scheduler feeding one serial BCD-to-Excess-3 digit converter.
// A granted word is converted one digit per cycle (LSB first) and held in DONE until consumed.
module bcd_excess3_sched #(
  parameter int N_DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_excess3_sched_if.slave     bus
);
  localparam int W     = 4 * N_DIGITS;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t           state_q;
  logic [W-1:0]     word_q;
  logic [W-1:0]     result_q;
  logic [W-1:0]     result_d;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;
  logic             src_q;
  logic             last_q;
  logic             valid_q;
  logic             busy_q;

  logic             grant0;
  logic             grant1;
  logic [3:0]       digit;
  logic [3:0]       digit_e3;
  logic             digit_bad;

  // last_q remembers the most recent winner so a tie goes to the other requester.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    digit    = '0;
    result_d = result_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        digit = word_q[i*4 +: 4];
      end
    end
    digit_bad = (digit > 4'd9);
    digit_e3  = digit_bad ? 4'd0 : (digit + 4'd3);
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        result_d[i*4 +: 4] = digit_e3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      word_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      src_q    <= 1'b0;
      last_q   <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            word_q  <= grant1 ? bus.req1_data : bus.req0_data;
            src_q   <= grant1;
            last_q  <= grant1;
            err_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          result_q <= result_d;
          err_q    <= err_q | digit_bad;
          // idx stops at the last digit instead of wrapping; it is cleared on the next grant.
          if (idx_q == LAST_IDX) begin
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = result_q;
  assign bus.out_err    = err_q;
  assign bus.out_src    = src_q;
  assign bus.busy       = busy_q;

endmodule
